// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered read data, occupancy flags,
// synchronous flush and sticky overflow/underflow error flags.
module sync_fifo_param #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 32,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     write,
   input  logic [WIDTH-1:0]         din,
   input  logic                     read,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic [$clog2(DEPTH):0]   n_elements,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clear_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign empty        = (n_elements == '0);
   assign full         = (n_elements == FULL_CNT);
   assign almost_full  = (n_elements >= AF_CNT);
   assign almost_empty = (n_elements <= AE_CNT);

   assign wr_ok = write && !full  && !flush;
   assign rd_ok = read  && !empty && !flush;

   // Storage is deliberately not reset; occupancy tracking alone defines validity.
   always_ff @(posedge clock) begin
      if (wr_ok)
         mem[wr_ptr] <= din;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         n_elements <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else if (flush) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         n_elements <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= rd_ok;
         if (wr_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
            dout   <= mem[rd_ptr];
         end
         case ({wr_ok, rd_ok})
            2'b10:   n_elements <= n_elements + CW'(1);
            2'b01:   n_elements <= n_elements - CW'(1);
            default: n_elements <= n_elements;
         endcase
      end
   end

   // A new error condition in the same cycle as clear_err keeps the flag set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (write && full)  || (overflow  && !clear_err);
         underflow <= (read  && empty) || (underflow && !clear_err);
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default parameters.
module tb_sync_fifo_param;

   logic       clock = 1'b0;
   logic       reset;
   logic       flush;
   logic       write;
   logic [7:0] din;
   logic       read;
   logic [7:0] dout;
   logic       dout_valid;
   logic [5:0] n_elements;
   logic       empty, full, almost_empty, almost_full;
   logic       overflow, underflow;
   logic       clear_err;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] q[$];
   logic [7:0] exp;

   sync_fifo_param #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
      .clock(clock), .reset(reset), .flush(flush), .write(write), .din(din),
      .read(read), .dout(dout), .dout_valid(dout_valid), .n_elements(n_elements),
      .empty(empty), .full(full), .almost_empty(almost_empty),
      .almost_full(almost_full), .overflow(overflow), .underflow(underflow),
      .clear_err(clear_err)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0;
      din = 8'h00; clear_err = 1'b0;
      step(); step();
      checks++;
      if (n_elements !== 6'd0 || empty !== 1'b1 || full !== 1'b0) begin
         errors++;
         $display("FAIL reset_occupancy: n=%0d empty=%b full=%b, want n=0 empty=1 full=0", n_elements, empty, full);
      end
      checks++;
      if (dout !== 8'h00 || dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: dout=%h dv=%b ovf=%b udf=%b, want 00 0 0 0", dout, dout_valid, overflow, underflow);
      end
      reset = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 32; i++) begin
         write = 1'b1; din = 8'(i);
         step();
         checks++;
         if (n_elements !== 6'(i) || full !== (i == 32) || almost_full !== (i >= 28) ||
             almost_empty !== (i <= 4) || empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_%0d: n=%0d full=%b af=%b ae=%b empty=%b, want n=%0d full=%b af=%b ae=%b empty=0",
                     i, n_elements, full, almost_full, almost_empty, empty, i, i == 32, i >= 28, i <= 4);
         end
      end
      din = 8'h33;
      step();
      write = 1'b0;
      checks++;
      if (overflow !== 1'b1 || n_elements !== 6'd32) begin
         errors++;
         $display("FAIL overflow_set: ovf=%b n=%0d, want ovf=1 n=32", overflow, n_elements);
      end
   endtask

   task automatic test_drain();
      for (int i = 1; i <= 32; i++) begin
         read = 1'b1;
         step();
         checks++;
         if (dout !== 8'(i) || dout_valid !== 1'b1 || n_elements !== 6'(32 - i)) begin
            errors++;
            $display("FAIL drain_%0d: dout=%h dv=%b n=%0d, want dout=%h dv=1 n=%0d", i, dout, dout_valid, n_elements, 8'(i), 32 - i);
         end
      end
      step();
      read = 1'b0;
      checks++;
      if (underflow !== 1'b1 || dout !== 8'h20 || dout_valid !== 1'b0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL underflow_set: udf=%b dout=%h dv=%b empty=%b, want 1 20 0 1", underflow, dout, dout_valid, empty);
      end
      step();
      checks++;
      if (dout !== 8'h20 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL dout_hold: dout=%h dv=%b, want 20 0", dout, dout_valid);
      end
   endtask

   task automatic test_clear_err();
      clear_err = 1'b1; read = 1'b1;
      step();
      checks++;
      if (underflow !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_set_wins: udf=%b ovf=%b, want udf=1 ovf=0", underflow, overflow);
      end
      read = 1'b0;
      step();
      clear_err = 1'b0;
      checks++;
      if (underflow !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL clear_err: udf=%b ovf=%b, want 0 0", underflow, overflow);
      end
   endtask

   task automatic test_wrap();
      q.delete();
      for (int i = 0; i < 16; i++) begin
         write = 1'b1; din = 8'(8'h40 + i); q.push_back(din);
         step();
      end
      for (int k = 0; k < 40; k++) begin
         write = 1'b1; read = 1'b1; din = 8'(8'h80 + k); q.push_back(din);
         step();
         exp = q.pop_front();
         checks++;
         if (dout !== exp || dout_valid !== 1'b1 || n_elements !== 6'd16) begin
            errors++;
            $display("FAIL wrap_rw_%0d: dout=%h dv=%b n=%0d, want dout=%h dv=1 n=16", k, dout, dout_valid, n_elements, exp);
         end
      end
      write = 1'b0;
      for (int k = 0; k < 16; k++) begin
         step();
         exp = q.pop_front();
         checks++;
         if (dout !== exp || n_elements !== 6'(15 - k)) begin
            errors++;
            $display("FAIL wrap_drain_%0d: dout=%h n=%0d, want dout=%h n=%0d", k, dout, n_elements, exp, 15 - k);
         end
      end
      read = 1'b0;
   endtask

   task automatic test_full_rw();
      q.delete();
      for (int i = 0; i < 32; i++) begin
         write = 1'b1; din = 8'(8'hC0 + i); q.push_back(din);
         step();
      end
      read = 1'b1; din = 8'hEE;
      step();
      exp = q.pop_front();
      checks++;
      if (n_elements !== 6'd31 || dout !== exp || overflow !== 1'b1) begin
         errors++;
         $display("FAIL full_rw: n=%0d dout=%h ovf=%b, want n=31 dout=%h ovf=1", n_elements, dout, overflow, exp);
      end
      write = 1'b0;
      for (int k = 0; k < 31; k++) begin
         step();
         exp = q.pop_front();
         checks++;
         if (dout !== exp || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_rw_drain_%0d: dout=%h dv=%b, want dout=%h dv=1", k, dout, dout_valid, exp);
         end
      end
      write = 1'b1; din = 8'h5A;
      step();
      checks++;
      if (n_elements !== 6'd1 || dout_valid !== 1'b0 || underflow !== 1'b1 || dout !== 8'hDF) begin
         errors++;
         $display("FAIL empty_rw: n=%0d dv=%b udf=%b dout=%h, want n=1 dv=0 udf=1 dout=df", n_elements, dout_valid, underflow, dout);
      end
      write = 1'b0;
      step();
      read = 1'b0;
      checks++;
      if (dout !== 8'h5A || dout_valid !== 1'b1 || empty !== 1'b1) begin
         errors++;
         $display("FAIL empty_rw_read: dout=%h dv=%b empty=%b, want 5a 1 1", dout, dout_valid, empty);
      end
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 10; i++) begin
         write = 1'b1; din = 8'(8'h10 + i);
         step();
      end
      flush = 1'b1; din = 8'h99;
      step();
      flush = 1'b0;
      checks++;
      if (n_elements !== 6'd0 || empty !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'h5A) begin
         errors++;
         $display("FAIL flush: n=%0d empty=%b dv=%b dout=%h, want n=0 empty=1 dv=0 dout=5a", n_elements, empty, dout_valid, dout);
      end
      din = 8'hAA;
      step();
      write = 1'b0; read = 1'b1;
      step();
      read = 1'b0;
      checks++;
      if (dout !== 8'hAA || dout_valid !== 1'b1 || n_elements !== 6'd0) begin
         errors++;
         $display("FAIL flush_then_rw: dout=%h dv=%b n=%0d, want aa 1 0", dout, dout_valid, n_elements);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 33; i++) begin
         write = 1'b1; din = 8'(i);
         step();
      end
      write = 1'b0; flush = 1'b1;
      step();
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         write = 1'b1; din = 8'(8'h60 + i);
         step();
      end
      write = 1'b0; read = 1'b1;
      step();
      read = 1'b0;
      checks++;
      if (n_elements !== 6'd5 || overflow !== 1'b1 || dout !== 8'h60) begin
         errors++;
         $display("FAIL async_pre: n=%0d ovf=%b dout=%h, want 5 1 60", n_elements, overflow, dout);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (n_elements !== 6'd0 || overflow !== 1'b0 || dout !== 8'h00 || empty !== 1'b1 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: n=%0d ovf=%b dout=%h empty=%b dv=%b, want 0 0 00 1 0", n_elements, overflow, dout, empty, dout_valid);
      end
      reset = 1'b0; write = 1'b1; din = 8'h77;
      step();
      write = 1'b0;
      checks++;
      if (n_elements !== 6'd1) begin
         errors++;
         $display("FAIL first_edge_write: n=%0d, want 1", n_elements);
      end
      read = 1'b1;
      step();
      read = 1'b0;
      checks++;
      if (dout !== 8'h77 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_read: dout=%h dv=%b, want 77 1", dout, dout_valid);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_clear_err();
      test_wrap();
      test_full_rw();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 32: entry count; power of two, >= 4.
REQ-003 The module SHALL have parameter AF_LEVEL, default DEPTH-4: almost_full asserts when n_elements >= AF_LEVEL.
REQ-004 The module SHALL have parameter AE_LEVEL, default 4: almost_empty asserts when n_elements <= AE_LEVEL.
REQ-005 The module SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-006 The module SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 The module SHALL have port flush  in  1  synchronous empty request.
REQ-008 The module SHALL have port write  in  1  write request.
REQ-009 The module SHALL have port din  in  WIDTH  write data.
REQ-010 The module SHALL have port read  in  1  read request.
REQ-011 The module SHALL have port dout  out  WIDTH  registered read data.
REQ-012 The module SHALL have port dout_valid  out  1  one-cycle pulse, dout updated this cycle.
REQ-013 The module SHALL have port n_elements  out  log2(DEPTH)+1  current occupancy.
REQ-014 The module SHALL have ports empty, full, almost_empty, almost_full  out  1 each  occupancy flags.
REQ-015 The module SHALL have ports overflow, underflow  out  1 each  sticky error flags.
REQ-016 The module SHALL have port clear_err  in  1  clears sticky error flags.

Function
REQ-017 Write SHALL be accepted iff write && !full && !flush; accepted write stores din at write pointer, pointer +1 modulo DEPTH.
REQ-018 Read SHALL be accepted iff read && !empty && !flush; entry at read pointer loaded into dout at the edge, pointer +1 modulo DEPTH.
REQ-019 Read latency SHALL be one cycle: dout and dout_valid=1 appear the cycle after the request cycle; dout holds its value otherwise.
REQ-020 n_elements SHALL change by +1 for a lone accepted write, -1 for a lone accepted read, 0 for both accepted in the same cycle.
REQ-021 When full with read and write both asserted: read accepted, write rejected, n_elements decrements.
REQ-022 When empty with read and write both asserted: write accepted, read rejected (no fall-through), dout_valid stays 0 next cycle.
REQ-023 empty = (n_elements==0), full = (n_elements==DEPTH), almost flags per REQ-003/004; all combinational from registered n_elements.
REQ-024 overflow SHALL set on any cycle with write && full; underflow SHALL set on any cycle with read && empty; both hold until clear_err.
REQ-025 clear_err SHALL clear both sticky flags at the edge; a set condition in the same cycle SHALL win.
REQ-026 flush SHALL zero both pointers and n_elements and force dout_valid to 0 next cycle; flush overrides read/write that cycle; dout and memory contents unchanged.
REQ-027 Pointer wrap SHALL be seamless: no lost or duplicated entry across the DEPTH-1 to 0 boundary.

Reset
REQ-028 reset asserted SHALL immediately, without a clock edge, set pointers=0, n_elements=0, dout=0, dout_valid=0, overflow=0, underflow=0.
REQ-029 Memory contents SHALL NOT be reset; reset asserted mid-operation SHALL discard all in-flight reads and stored entries.
REQ-030 First accepted operation SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-031 Defaults; write 0x01..0x20 (32 words) -> full=1, almost_full from 28th write, n_elements=32; 33rd write -> overflow=1, contents unchanged.
REQ-032 Read 32 words -> dout 0x01..0x20 in order, each one cycle after request with dout_valid pulse; then read -> underflow=1, dout stays 0x20.
REQ-033 Hold 16 entries, assert read+write 40 cycles (pointer wrap) -> n_elements stays 16, output order equals input order.
REQ-034 Full, read+write asserted together -> n_elements 31, write data not stored; empty, read+write -> n_elements 1, no dout_valid.
REQ-035 10 entries, assert flush with write -> n_elements=0, empty=1 next cycle; subsequent write 0xAA then read -> dout=0xAA.
REQ-036 Assert reset asynchronously between edges with 5 entries and overflow=1 -> n_elements=0, overflow=0, dout=0 before next edge.
